cdc_hs_bus: RTL and testbench

- Parametrised successor of the enable-qualified clk_a→clk_b data crossing.
- Moves a WIDTH-bit word from clk_a to clk_b with a 4-phase-free toggle req/ack handshake.
- The source holds the word stable until the destination acknowledges, so no enable timing assumptions are needed.
- Sits between any clk_a producer and clk_b consumer where word rate is low relative to either clock.

---
 rtl/cdc_pkg.sv | 12 +
 rtl/cdc_sync_bit.sv | 21 ++
 rtl/cdc_hs_bus.sv | 129 ++++++++++++
 tb/tb_cdc_hs_bus.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the clk_a -> clk_b toggle-handshake word crossing.
package cdc_pkg;

  // Shortest synchroniser chain the crossing will build.
  localparam int SYNC_STAGES_MIN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } src_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/cdc_hs_bus.sv
// WIDTH-bit word crossing from clk_a to clk_b using a toggle req/ack handshake.
// The source holds the word in hold_reg until the destination acknowledges,
// so hold_reg is only ever sampled by clk_b while it is stable.
// Optional build macro CDC_DST_READY_EN adds dst_ready back-pressure: the
// delivered word is held with dst_valid high until dst_ready, and the ack is
// returned only on acceptance.
//
// Source FSM:
//   state | meaning
//   IDLE  | src_ready=1, waiting for src_valid
//   WAIT  | word held in hold_reg, waiting for ack toggle to match req toggle
module cdc_hs_bus
  import cdc_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk_a,
  input  logic             arstn,
  input  logic             clk_b,
  input  logic             brstn,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_ready,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
`ifdef CDC_DST_READY_EN
  input  logic             dst_ready,
`endif
  output logic             busy
);

  // Chains shorter than the minimum are stretched to it.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  src_state_t       state_q, state_d;
  logic             hold_en;
  logic             req_tgl;
  logic [WIDTH-1:0] hold_reg;
  logic             ack_sync;

  logic             req_sync;
  logic             req_seen;
  logic             req_new;
  logic             ack_tgl;

  // Source next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    src_ready = 1'b0;
    hold_en   = 1'b0;
    case (state_q)
      IDLE: begin
        src_ready = 1'b1;
        if (src_valid) begin
          hold_en = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ack_sync == req_tgl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Source state, request toggle and held word.
  always_ff @(posedge clk_a or negedge arstn) begin
    if (!arstn) begin
      state_q  <= IDLE;
      req_tgl  <= 1'b0;
      hold_reg <= '0;
    end else begin
      state_q <= state_d;
      if (hold_en) begin
        req_tgl  <= ~req_tgl;
        hold_reg <= src_data;
      end
    end
  end

  assign busy = ~src_ready;

  cdc_sync_bit #(.STAGES(STAGES)) u_req_sync (
    .clk  (clk_b),
    .rstn (brstn),
    .d    (req_tgl),
    .q    (req_sync)
  );

  cdc_sync_bit #(.STAGES(STAGES)) u_ack_sync (
    .clk  (clk_a),
    .rstn (arstn),
    .d    (ack_tgl),
    .q    (ack_sync)
  );

  // A change on the synchronised request marks a new word in hold_reg.
  assign req_new = req_sync ^ req_seen;

  // Destination edge register, word capture and acknowledge.
  always_ff @(posedge clk_b or negedge brstn) begin
    if (!brstn) begin
      req_seen  <= 1'b0;
      ack_tgl   <= 1'b0;
      dst_valid <= 1'b0;
      dst_data  <= RESET_VAL;
    end else begin
      req_seen <= req_sync;
`ifdef CDC_DST_READY_EN
      if (req_new) begin
        dst_valid <= 1'b1;
        dst_data  <= hold_reg;
      end else if (dst_valid && dst_ready) begin
        dst_valid <= 1'b0;
        ack_tgl   <= req_seen;
      end
`else
      dst_valid <= req_new;
      if (req_new) begin
        dst_data <= hold_reg;
        ack_tgl  <= req_sync;
      end
`endif
    end
  end

endmodule

// File: tb/tb_cdc_hs_bus.sv
// Self-checking bench for cdc_hs_bus: a queue of accepted words is the
// reference; every delivered word must be the oldest outstanding one.
`timescale 1ns/1ps
module tb_cdc_hs_bus;

  localparam int S = 2;

  realtime ha = 5.0;
  realtime hb = 13.5;

  logic       clk_a = 1'b0;
  logic       clk_b = 1'b0;
  logic       arstn = 1'b0;
  logic       brstn = 1'b0;
  logic       src_valid = 1'b0;
  logic [3:0] src_data = 4'h0;
  logic       src_ready;
  logic       dst_valid;
  logic [3:0] dst_data;
  logic       busy;
  logic       dst_ready_tb = 1'b1;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int rdy_mode = 0;
  bit rt_check_en = 1'b1;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  logic [3:0] last_word = 4'h0;
  logic       prev_ready = 1'b1;
  realtime    acc_t = 0.0;
  realtime    el;

  cdc_hs_bus #(.WIDTH(4), .SYNC_STAGES(S), .RESET_VAL(4'h0)) dut (
    .clk_a     (clk_a),
    .arstn     (arstn),
    .clk_b     (clk_b),
    .brstn     (brstn),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_data  (dst_data),
`ifdef CDC_DST_READY_EN
    .dst_ready (dst_ready_tb),
`endif
    .busy      (busy)
  );

  initial forever #(ha) clk_a = ~clk_a;
  initial forever #(hb) clk_b = ~clk_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source-side monitor: records accepted words and checks src_ready/busy.
  always @(negedge clk_a) begin
    if (!arstn) begin
      chk("rst_src_ready", {31'b0, src_ready}, 1);
      chk("rst_busy", {31'b0, busy}, 0);
      prev_ready = 1'b1;
    end else begin
      chk("busy_is_not_ready", {31'b0, busy}, {31'b0, !src_ready});
      if (src_ready) chk("ready_with_word_in_flight", exp_q.size(), 0);
      if (src_ready && !prev_ready && rt_check_en) begin
        el = $realtime - acc_t;
        checks++;
        if (el > (S + 2) * (2.0 * ha + 2.0 * hb)) begin
          failures++;
          $display("FAIL round_trip actual=%0.1fns required<=%0.1fns", el, (S + 2) * (2.0 * ha + 2.0 * hb));
        end
      end
      prev_ready = src_ready;
      if (src_ready && src_valid) begin
        exp_q.push_back(src_data);
        acc_t = $realtime + ha;
      end
    end
  end

  // Destination-side monitor: every delivered word is the oldest accepted one.
  always @(negedge clk_b) begin
    if (!brstn) begin
      chk("rst_dst_valid", {31'b0, dst_valid}, 0);
      chk("rst_dst_data", {28'b0, dst_data}, 0);
      last_word = 4'h0;
    end else if (dst_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_dst_valid actual=1 required=0 data=%0h at %0t", dst_data, $time);
      end else begin
        chk("dst_data_vs_model", {28'b0, dst_data}, {28'b0, exp_q[0]});
        if (dst_ready_tb) begin
          last_word = exp_q.pop_front();
          got_q.push_back(last_word);
          strobes++;
        end
      end
    end else begin
      chk("dst_data_hold", {28'b0, dst_data}, {28'b0, last_word});
    end
  end

  // dst_ready driver (only reaches the DUT in the back-pressure build).
  initial forever begin
    @(posedge clk_b); #1;
    case (rdy_mode)
      0:       dst_ready_tb = 1'b1;
      1:       dst_ready_tb = 1'($urandom_range(0, 1));
      default: dst_ready_tb = 1'b0;
    endcase
  end

  task automatic cyc_a(input int n);
    repeat (n) @(posedge clk_a);
    #1;
  endtask

  task automatic cyc_b(input int n);
    repeat (n) @(posedge clk_b);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!src_ready && n < 500) begin
      @(posedge clk_a); #1;
      n++;
    end
    checks++;
    if (!src_ready) begin
      failures++;
      $display("FAIL %s timeout src_ready actual=0 required=1", name);
    end
  endtask

  task automatic send(input logic [3:0] d);
    @(posedge clk_a); #1;
    wait_ready("send_wait_ready");
    src_valid = 1'b1;
    src_data  = d;
    @(posedge clk_a); #1;
    src_valid = 1'b0;
  endtask

  task automatic do_reset(input int nb);
    arstn = 1'b0;
    brstn = 1'b0;
    exp_q.delete();
    cyc_b(nb);
    arstn = 1'b1;
    brstn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, s0, n, guard;
    logic r;
    logic [3:0] sent_q[$];
    logic [3:0] d;

    // Reset then idle.
    do_reset(5);
    cyc_a(1);
    chk("idle_src_ready", {31'b0, src_ready}, 1);
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_dst_valid", {31'b0, dst_valid}, 0);
    chk("idle_dst_data", {28'b0, dst_data}, 0);
    cyc_b(50);
    chk("idle_no_strobes", strobes, 0);

    // Single word, clk_a 100 MHz, clk_b 37 MHz.
    send(4'hA);
    wait_ready("single_ready");
    cyc_b(4);
    chk("single_strobe_count", strobes, 1);
    chk("single_word", {28'b0, got_q[$]}, 32'hA);
    chk("single_dst_hold", {28'b0, dst_data}, 32'hA);

    // Stream 0..15 with clocks swapped.
    ha = 13.5; hb = 5.0;
    cyc_a(2);
    g0 = got_q.size();
    n = 0; guard = 0;
    src_valid = 1'b1;
    src_data  = 4'h0;
    while (n < 16 && guard < 2000) begin
      r = src_ready;
      @(posedge clk_a); #1;
      if (r) begin
        n++;
        src_data = n[3:0];
      end
      guard++;
    end
    src_valid = 1'b0;
    wait_ready("stream_ready");
    cyc_b(6);
    chk("stream_count", got_q.size() - g0, 16);
    for (int i = 0; i < 16 && g0 + i < got_q.size(); i++)
      chk("stream_order", {28'b0, got_q[g0 + i]}, i);

    // Source data changes while the word is in flight.
    ha = 5.0; hb = 13.5;
    cyc_a(2);
    g0 = got_q.size();
    send(4'h3);
    src_valid = 1'b1;
    src_data  = 4'hC;
    guard = 0;
    while (!src_ready && guard < 500) begin
      @(posedge clk_a); #1;
      guard++;
    end
    src_valid = 1'b0;
    cyc_b(3);
    chk("change_delivered_old", {28'b0, got_q[$]}, 32'h3);
    chk("change_dst_data", {28'b0, dst_data}, 32'h3);
    chk("change_single_delivery", got_q.size() - g0, 1);
    send(4'hC);
    wait_ready("change_reoffer_ready");
    cyc_b(4);
    chk("change_reoffer_word", {28'b0, got_q[$]}, 32'hC);
    chk("change_total", got_q.size() - g0, 2);

    // Reset one cycle after acceptance aborts the word.
    @(posedge clk_a); #1;
    wait_ready("abort_pre_ready");
    src_valid = 1'b1;
    src_data  = 4'h9;
    @(posedge clk_a); #1;
    src_valid = 1'b0;
    chk("abort_busy_after_accept", {31'b0, busy}, 1);
    @(posedge clk_a); #1;
    s0 = strobes;
    do_reset(5);
    cyc_b(40);
    chk("abort_no_strobe", strobes, s0);
    chk("abort_src_ready", {31'b0, src_ready}, 1);
    send(4'h5);
    wait_ready("abort_next_ready");
    cyc_b(4);
    chk("abort_next_word", {28'b0, got_q[$]}, 32'h5);
    chk("abort_next_count", strobes, s0 + 1);

    // Randomised words, gaps and (when present) back-pressure; equal clocks.
    ha = 4.0; hb = 4.0;
`ifdef CDC_DST_READY_EN
    rdy_mode = 1;
    rt_check_en = 1'b0;
`endif
    cyc_a(2);
    g0 = got_q.size();
    for (int i = 0; i < 30; i++) begin
      d = 4'($urandom_range(0, 15));
      sent_q.push_back(d);
      send(d);
      cyc_a($urandom_range(0, 5));
    end
    wait_ready("random_ready");
    cyc_b(8);
    rdy_mode = 0;
    cyc_b(4);
    chk("random_count", got_q.size() - g0, 30);
    for (int i = 0; i < 30 && g0 + i < got_q.size(); i++)
      chk("random_order", {28'b0, got_q[g0 + i]}, {28'b0, sent_q[i]});

`ifdef CDC_DST_READY_EN
    // Held dst_ready low: word and valid stay put, source stays in WAIT.
    ha = 5.0; hb = 13.5;
    rdy_mode = 2;
    cyc_b(2);
    send(4'h7);
    guard = 0;
    while (!dst_valid && guard < 50) begin
      cyc_b(1);
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_dst_valid_held", {31'b0, dst_valid}, 1);
      chk("bp_dst_data_stable", {28'b0, dst_data}, 32'h7);
      chk("bp_src_not_ready", {31'b0, src_ready}, 0);
      cyc_b(1);
    end
    rdy_mode = 0;
    wait_ready("bp_release_ready");
    cyc_b(4);
    chk("bp_word", {28'b0, got_q[$]}, 32'h7);
    chk("bp_dst_valid_clear", {31'b0, dst_valid}, 0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
